// File: rtl/one_mhz_bus_sequencer_if.sv
// rtl/one_mhz_bus_sequencer_if.sv - CPU/VIA-facing signal bundle of the 1MHz bus sequencer
interface one_mhz_bus_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             CLK2_en;
  logic             SLOW_SEL;
  logic             CPU_en;
  logic             PERIPH_en;
  logic             PERIPH_ACCESS;
  logic             PHASE;
  logic             STRETCH;
  logic [CNT_W-1:0] STALL_COUNT;

  modport master (
    input  CLK2_en, SLOW_SEL,
    output CPU_en, PERIPH_en, PERIPH_ACCESS, PHASE, STRETCH, STALL_COUNT
  );

  modport slave (
    output CLK2_en, SLOW_SEL,
    input  CPU_en, PERIPH_en, PERIPH_ACCESS, PHASE, STRETCH, STALL_COUNT
  );
endinterface

// File: rtl/one_mhz_bus_sequencer.sv
// rtl/one_mhz_bus_sequencer.sv - stretches 2MHz CPU cycles onto aligned 1MHz VIA periods
module one_mhz_bus_sequencer #(
  parameter logic PHASE_INIT = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   nRESET,
  one_mhz_bus_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q;
  logic             suppress;
  logic [CNT_W-1:0] stall_count_q;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q       <= IDLE;
      phase_q       <= PHASE_INIT;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.CLK2_en) begin
        phase_q <= ~phase_q;
      end
      if (bus.CLK2_en && suppress && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  // SLOW_SEL only matters in IDLE; once committed, the access runs to its release tick.
  always_comb begin
    state_d  = state_q;
    suppress = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CLK2_en && bus.SLOW_SEL) begin
          suppress = 1'b1;
          state_d  = phase_q ? ACCESS : ALIGN;
        end
      end
      ALIGN: begin
        if (bus.CLK2_en) begin
          suppress = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.CLK2_en) begin
          if (phase_q) begin
            state_d = IDLE;
          end else begin
            suppress = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release tick of an access is shared with PERIPH_en, so the VIA commits as the CPU proceeds.
  assign bus.CPU_en        = bus.CLK2_en & ~suppress & nRESET;
  assign bus.PERIPH_en     = bus.CLK2_en & phase_q & nRESET;
  assign bus.PERIPH_ACCESS = (state_q == ACCESS) & nRESET;
  assign bus.STRETCH       = (state_q != IDLE) & nRESET;
  assign bus.PHASE         = phase_q;
  assign bus.STALL_COUNT   = stall_count_q;
endmodule

// File: tb/tb_one_mhz_bus_sequencer.sv
// tb/tb_one_mhz_bus_sequencer.sv - directed bench with a stall-budget model of the 1MHz sequencer
module tb_one_mhz_bus_sequencer;
  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  logic clk2_en = 1'b0;
  logic slow_sel = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  one_mhz_bus_sequencer_if #(.CNT_W(16)) bus16 ();
  one_mhz_bus_sequencer_if #(.CNT_W(2))  bus2 ();

  assign bus16.CLK2_en  = clk2_en;
  assign bus16.SLOW_SEL = slow_sel;
  assign bus2.CLK2_en   = clk2_en;
  assign bus2.SLOW_SEL  = slow_sel;

  one_mhz_bus_sequencer #(.PHASE_INIT(1'b0), .CNT_W(16)) dut16 (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus16)
  );

  one_mhz_bus_sequencer #(.PHASE_INIT(1'b0), .CNT_W(2)) dut2 (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a slow access costs a fixed budget of withheld ticks decided at request time.
  bit armed = 0;
  bit m_phase = 0;
  bit m_busy = 0;
  int m_left = 0;
  bit m_access = 0;
  int m_cnt16 = 0;
  int m_cnt2 = 0;
  int n_cpu = 0;
  int n_periph = 0;
  int n_pa_ticks = 0;

  always @(negedge CLK) begin
    bit supp;
    if (!nRESET) begin
      armed = 1;
      chk("rst_cpu_en", int'(bus16.CPU_en), 0);
      chk("rst_periph_en", int'(bus16.PERIPH_en), 0);
      chk("rst_periph_access", int'(bus16.PERIPH_ACCESS), 0);
      chk("rst_stretch", int'(bus16.STRETCH), 0);
      chk("rst2_cpu_en", int'(bus2.CPU_en), 0);
      m_phase = 0; m_busy = 0; m_left = 0; m_access = 0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (armed) begin
      if (!m_busy) supp = clk2_en && slow_sel;
      else         supp = clk2_en && (m_left > 0);
      chk("cpu_en", int'(bus16.CPU_en), int'(clk2_en && !supp));
      chk("periph_en", int'(bus16.PERIPH_en), int'(clk2_en && m_phase));
      chk("periph_access", int'(bus16.PERIPH_ACCESS), int'(m_access));
      chk("stretch", int'(bus16.STRETCH), int'(m_busy));
      chk("phase", int'(bus16.PHASE), int'(m_phase));
      chk("stall_count", int'(bus16.STALL_COUNT), m_cnt16);
      chk("cpu_en_w2", int'(bus2.CPU_en), int'(clk2_en && !supp));
      chk("stall_count_w2", int'(bus2.STALL_COUNT), m_cnt2);
      n_cpu      += int'(bus16.CPU_en);
      n_periph   += int'(bus16.PERIPH_en);
      n_pa_ticks += int'(bus16.PERIPH_ACCESS && clk2_en);
      if (clk2_en) begin
        if (!m_busy && slow_sel) begin
          m_busy = 1;
          m_left = m_phase ? 1 : 2;
          if (m_phase) m_access = 1;
        end else if (m_busy) begin
          if (m_left > 0) begin
            m_left--;
            if (m_phase) m_access = 1;
          end else begin
            m_busy = 0;
            m_access = 0;
          end
        end
        if (supp) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        m_phase = !m_phase;
      end
    end
  end

  task automatic tick(input logic slow);
    clk2_en = 1'b1;
    slow_sel = slow;
    @(posedge CLK); #1;
    clk2_en = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    clk2_en = 1'b0;
    slow_sel = 1'b0;
    @(posedge CLK); #1;
    nRESET = 1'b1;
  endtask

  int s_cpu, s_periph, s_pa;

  task automatic snap();
    @(posedge CLK); #1;
    s_cpu = n_cpu; s_periph = n_periph; s_pa = n_pa_ticks;
  endtask

  initial begin
    @(posedge CLK); #1;
    do_reset();
    chk("lit_reset_count", int'(bus16.STALL_COUNT), 0);
    chk("lit_reset_phase", int'(bus16.PHASE), 0);

    // request at PHASE=1
    snap();
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    @(posedge CLK); #1;
    chk("lit_t1_count", int'(bus16.STALL_COUNT), 2);
    chk("lit_t1_cpu_pulses", n_cpu - s_cpu, 2);
    chk("lit_t1_pa_ticks", n_pa_ticks - s_pa, 2);
    chk("lit_t1_periph_ticks", n_periph - s_periph, 2);

    // request at PHASE=0, SLOW_SEL held through ALIGN/ACCESS
    do_reset();
    snap();
    repeat (4) tick(1'b1);
    tick(1'b0);
    @(posedge CLK); #1;
    chk("lit_t2_count", int'(bus16.STALL_COUNT), 3);
    chk("lit_t2_cpu_pulses", n_cpu - s_cpu, 2);
    chk("lit_t2_pa_ticks", n_pa_ticks - s_pa, 2);

    // back-to-back accesses with SLOW_SEL held
    do_reset();
    snap();
    tick(1'b0);
    repeat (7) tick(1'b1);
    @(posedge CLK); #1;
    chk("lit_t3_count", int'(bus16.STALL_COUNT), 5);
    chk("lit_t3_cpu_pulses", n_cpu - s_cpu, 3);
    chk("lit_t3_stretch_idle", int'(bus16.STRETCH), 0);
    tick(1'b0);

    // SLOW_SEL dropped during ALIGN/ACCESS
    do_reset();
    snap();
    tick(1'b1);
    repeat (3) tick(1'b0);
    @(posedge CLK); #1;
    chk("lit_t4_count", int'(bus16.STALL_COUNT), 3);
    chk("lit_t4_cpu_pulses", n_cpu - s_cpu, 1);

    // reset in the middle of ACCESS
    do_reset();
    tick(1'b0);
    tick(1'b1);
    chk("lit_t5_in_access", int'(bus16.PERIPH_ACCESS), 1);
    nRESET = 1'b0;
    clk2_en = 1'b1;
    @(posedge CLK); #1;
    nRESET = 1'b1;
    clk2_en = 1'b0;
    chk("lit_t5_count", int'(bus16.STALL_COUNT), 0);
    chk("lit_t5_phase", int'(bus16.PHASE), 0);
    chk("lit_t5_stretch", int'(bus16.STRETCH), 0);
    snap();
    tick(1'b0);
    chk("lit_t5_cpu_first", n_cpu - s_cpu, 1);

    // saturation of the 2-bit counter
    do_reset();
    repeat (4) begin
      tick(1'b1);
      repeat (4) tick(1'b0);
    end
    @(posedge CLK); #1;
    chk("lit_t6_count_w2", int'(bus2.STALL_COUNT), 3);
    chk("lit_t6_count_w16", int'(bus16.STALL_COUNT), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
